// File: rtl/crc_pkg.sv
// Shared types and sizing helpers for the CRC frame transmitter.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CRC = 2'd1,
    ST_SEND     = 2'd2
  } state_e;

  // Frame length in bytes: data word followed by the CRC.
  function automatic int calc_nbytes(input int dwidth, input int crc_width);
    return dwidth / 8 + crc_width / 8;
  endfunction

endpackage

// File: rtl/crc_byte_serializer.sv
// Frame register plus byte index: emits data bytes then CRC bytes, MSB first, with a last flag.
module crc_byte_serializer
  import crc_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CRC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 load_i,
  input  logic [DWIDTH-1:0]    data_i,
  input  logic                 start_i,
  input  logic [CRC_WIDTH-1:0] crc_i,
  input  logic                 tx_ready_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  output logic                 tx_last_o,
  output logic                 last_hs_o
);

  localparam int NBYTES = calc_nbytes(DWIDTH, CRC_WIDTH);
  localparam int FW     = NBYTES * 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  logic [FW-1:0] frame_q, frame_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          active_q, active_d;
  logic          is_last, hs;

  assign is_last = (idx_q == LAST_IDX);
  assign hs      = active_q & tx_ready_i;

  // The current byte always sits in the top byte of frame_q; it shifts only on a handshake.
  always_comb begin
    frame_d  = frame_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (load_i) begin
      frame_d  = {data_i, {CRC_WIDTH{1'b0}}};
      idx_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      frame_d[CRC_WIDTH-1:0] = crc_i;
      idx_d                  = '0;
      active_d               = 1'b1;
    end else if (hs) begin
      if (is_last) begin
        active_d = 1'b0;
      end else begin
        frame_d = frame_q << 8;
        idx_d   = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frame_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign tx_valid_o = active_q;
  assign tx_data_o  = active_q ? frame_q[FW-1 -: 8] : 8'h00;
  assign tx_last_o  = active_q & is_last;
  assign last_hs_o  = hs & is_last;

endmodule

// File: rtl/crc_frame_tx.sv
// Frame sequencer: accepts a word, launches the CRC calculator, then streams data + CRC bytes.
// Handshakes: a transfer happens on a clock edge where valid & ready are both high; valid never drops before it.
module crc_frame_tx
  import crc_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int CRC_WIDTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [DWIDTH-1:0]    inData,
  output logic                 crcEn,
  output logic [DWIDTH-1:0]    crcData,
  input  logic                 crcReady,
  input  logic [CRC_WIDTH-1:0] crcSeq,
  output logic [7:0]           txData,
  output logic                 txValid,
  output logic                 txLast,
  input  logic                 txReady,
  output logic                 errPulse,
  output logic [15:0]          frameCnt,
  output state_e               dbg_state_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              crc_en_q, crc_en_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [DWIDTH-1:0] crc_data_q, crc_data_d;
  logic              capture, done, last_hs;

  assign capture = (state_q == ST_IDLE) & inValid;
  // ready_q is forced high at launch so a level already high then cannot count as completion.
  assign done    = (state_q == ST_WAIT_CRC) & crcReady & ~ready_q;

  always_comb begin
    state_d     = state_q;
    crc_en_d    = 1'b0;
    err_d       = 1'b0;
    ready_d     = ready_q;
    timer_d     = timer_q;
    frame_cnt_d = frame_cnt_q;
    crc_data_d  = crc_data_q;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          crc_data_d = inData;
          crc_en_d   = 1'b1;
          ready_d    = 1'b1;
          timer_d    = '0;
          state_d    = ST_WAIT_CRC;
        end
      end
      ST_WAIT_CRC: begin
        ready_d = crcReady;
        timer_d = timer_q + TW'(1);
        if (done) begin
          state_d = ST_SEND;
        end else if (timer_q == TIMER_MAX) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (last_hs) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      crc_en_q    <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      timer_q     <= '0;
      frame_cnt_q <= '0;
      crc_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      crc_en_q    <= crc_en_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
      crc_data_q  <= crc_data_d;
    end
  end

  crc_byte_serializer #(
    .DWIDTH    (DWIDTH),
    .CRC_WIDTH (CRC_WIDTH)
  ) u_ser (
    .clk        (clk),
    .rstN       (rstN),
    .load_i     (capture),
    .data_i     (inData),
    .start_i    (done),
    .crc_i      (crcSeq),
    .tx_ready_i (txReady),
    .tx_data_o  (txData),
    .tx_valid_o (txValid),
    .tx_last_o  (txLast),
    .last_hs_o  (last_hs)
  );

  assign inReady     = (state_q == ST_IDLE);
  assign crcEn       = crc_en_q;
  assign crcData     = crc_data_q;
  assign errPulse    = err_q;
  assign frameCnt    = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx with a behavioural CRC-8 (poly 0x07, init 0) calculator model.
module tb_crc_frame_tx;
  import crc_pkg::*;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int TO  = 64;
  localparam int LAT = 3;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  crc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic          inValid = 1'b0;
  logic          inReady;
  logic [DW-1:0] inData = '0;
  logic          crcEn;
  logic [DW-1:0] crcData;
  logic          crcReady;
  logic [CW-1:0] crcSeq;
  logic [7:0]    txData;
  logic          txValid, txLast;
  logic          txReady = 1'b1;
  logic          errPulse;
  logic [15:0]   frameCnt;
  state_e        dbg_state;

  crc_frame_tx #(.DWIDTH(DW), .CRC_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .inData(inData),
    .crcEn(crcEn), .crcData(crcData), .crcReady(crcReady), .crcSeq(crcSeq),
    .txData(txData), .txValid(txValid), .txLast(txLast), .txReady(txReady),
    .errPulse(errPulse), .frameCnt(frameCnt), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [7:0] crc8_word(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      c = (c[7] ^ w[i]) ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // ---------------- calculator model ----------------
  logic        stub_mode = 1'b0;
  int          calc_cnt;
  logic [31:0] calc_word;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      crcReady <= 1'b1;
      crcSeq   <= '0;
      calc_cnt <= 0;
      calc_word <= '0;
    end else if (crcEn) begin
      crcReady  <= 1'b0;
      calc_word <= crcData;
      calc_cnt  <= LAT;
    end else if (calc_cnt > 0 && !stub_mode) begin
      if (calc_cnt == 1) begin
        crcReady <= 1'b1;
        crcSeq   <= crc8_word(calc_word);
      end
      calc_cnt <= calc_cnt - 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  int         tx_count = 0;
  int         stall_seen = 0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rstN) begin
      if (prev_stall) begin
        check("stall_valid_held", txValid, 1'b1);
        check("stall_data_held", txData, prev_data);
        check("stall_last_held", txLast, prev_last);
      end
      if (txValid && txReady) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_extra: got byte %h last %b, required no byte", txData, txLast);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {txLast, txData}, e);
        end
        tx_count++;
      end
      if (txValid && !txReady) stall_seen++;
      prev_stall = txValid && !txReady;
      prev_data  = txData;
      prev_last  = txLast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [31:0] w, input logic [7:0] c);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, w[31-8*i -: 8]});
    exp_q.push_back({1'b1, c});
  endtask

  // Called at posedge+1; returns at posedge+1 right after the capturing edge.
  task automatic send_word(input logic [31:0] w, output int stalls, output bit ok);
    int guard;
    inValid = 1'b1;
    inData  = w;
    ok      = 1'b0;
    stalls  = 0;
    guard   = 0;
    while (!ok && guard < 400) begin
      @(negedge clk);
      ok = inReady;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
      guard++;
    end
    inValid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: word %h not accepted, required acceptance", w);
    end
  endtask

  task automatic wait_frame_done(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(exp_q.size() == 0 && dbg_state == ST_IDLE && !txValid) && guard < 600);
    if (guard >= 600) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[4];
  bit [2:0] pat;

  initial begin
    int   stalls, lat, en_cnt, guard, frames, en_k, err_k, err_cnt, tx_seen, base;
    bit   ok;
    vecs[0] = '{data: 32'h01020304, crc: 8'hE3};
    vecs[1] = '{data: 32'h00000000, crc: 8'h00};
    vecs[2] = '{data: 32'h00000001, crc: 8'h07};
    vecs[3] = '{data: 32'h00000080, crc: 8'h89};
    frames = 0;

    #12;
    check("rst_txValid", txValid, 1'b0);
    check("rst_txLast", txLast, 1'b0);
    check("rst_crcEn", crcEn, 1'b0);
    check("rst_errPulse", errPulse, 1'b0);
    check("rst_txData", txData, 8'h00);
    check("rst_crcData", crcData, 32'h0);
    check("rst_frameCnt", frameCnt, 16'h0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check("rst_inReady", inReady, 1'b1);
    @(posedge clk); #1;

    // Table of hand-computed frames: crcEn width, latency, bytes, frame count.
    for (int v = 0; v < 4; v++) begin
      push_frame(vecs[v].data, vecs[v].crc);
      send_word(vecs[v].data, stalls, ok);
      lat = 0; en_cnt = 0; guard = 0;
      while (!txValid && guard < 100) begin
        @(negedge clk);
        if (guard == 0) begin
          check("inReady_low_after_capture", inReady, 1'b0);
          check("crcData_captured", crcData, vecs[v].data);
        end
        if (crcEn) en_cnt++;
        if (!txValid) lat++;
        guard++;
      end
      check("crcEn_pulse_cycles", en_cnt, 1);
      check("first_byte_latency", lat, 2 + LAT);
      wait_frame_done("vec");
      frames++;
      check("frameCnt_vec", frameCnt, frames);
    end

    // txReady toggling 1-0-1 while the frame streams.
    pat = 3'b101;
    push_frame(32'hAABBCCDD, crc8_word(32'hAABBCCDD));
    send_word(32'hAABBCCDD, stalls, ok);
    guard = 0;
    while (!(exp_q.size() == 0 && dbg_state == ST_IDLE) && guard < 200) begin
      txReady = pat[guard % 3];
      @(posedge clk); #1;
      guard++;
    end
    txReady = 1'b1;
    wait_frame_done("stall");
    frames++;
    check("stalls_exercised", (stall_seen > 0), 1'b1);
    check("frameCnt_stall", frameCnt, frames);

    // Back-to-back words: the second waits for the whole first frame.
    push_frame(32'hFFFF0000, crc8_word(32'hFFFF0000));
    send_word(32'hFFFF0000, stalls, ok);
    check("b2b_first_no_wait", stalls, 0);
    push_frame(32'hFFFFFFFF, crc8_word(32'hFFFFFFFF));
    send_word(32'hFFFFFFFF, stalls, ok);
    check("b2b_second_wait_cycles", stalls, 2 + LAT + 5);
    wait_frame_done("b2b");
    frames += 2;
    check("frameCnt_b2b", frameCnt, frames);

    // Calculator never completes: timeout abort, then a normal frame.
    stub_mode = 1'b1;
    send_word(32'h12345678, stalls, ok);
    en_k = -1; err_k = -1; err_cnt = 0; tx_seen = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (crcEn && en_k < 0) en_k = k;
      if (errPulse) begin
        err_cnt++;
        if (err_k < 0) err_k = k;
      end
      if (txValid) tx_seen++;
    end
    check("timeout_err_delay", err_k - en_k, TO);
    check("timeout_err_once", err_cnt, 1);
    check("timeout_no_tx", tx_seen, 0);
    check("timeout_state_idle", dbg_state, ST_IDLE);
    check("timeout_frameCnt", frameCnt, frames);
    stub_mode = 1'b0;
    @(posedge clk); #1;
    push_frame(32'h5A5AA5A5, crc8_word(32'h5A5AA5A5));
    send_word(32'h5A5AA5A5, stalls, ok);
    wait_frame_done("after_timeout");
    frames++;
    check("frameCnt_after_timeout", frameCnt, frames);

    // Reset while byte 2 is on the bus.
    push_frame(32'hCAFEBABE, crc8_word(32'hCAFEBABE));
    base = tx_count;
    send_word(32'hCAFEBABE, stalls, ok);
    guard = 0;
    while (tx_count < base + 2 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reset_reached_byte2", tx_count - base, 2);
    check("reset_pre_valid", txValid, 1'b1);
    rstN = 1'b0;
    #1;
    exp_q.delete();
    check("reset_mid_txValid", txValid, 1'b0);
    check("reset_mid_txLast", txLast, 1'b0);
    check("reset_mid_frameCnt", frameCnt, 16'h0);
    check("reset_mid_crcData", crcData, 32'h0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check("reset_release_inReady", inReady, 1'b1);
    @(posedge clk); #1;
    push_frame(32'h01020304, 8'hE3);
    send_word(32'h01020304, stalls, ok);
    wait_frame_done("after_reset");
    check("frameCnt_after_reset", frameCnt, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
